// File: rtl/vga_timing_controller_if.sv
// Video timing bundle: scan position, sync/blank strobes and the buffer-swap handshake.
// master = timing generator, slave = pixel pipeline / frame-buffer manager.
interface vga_timing_controller_if;
    logic        swap_req;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        at_display_area;
    logic        pix_tick;
    logic        frame_start;
    logic        swap_ack;
    logic        buf_sel;

    modport master (
        input  swap_req,
        output hcount, vcount, hsync, vsync, at_display_area,
        output pix_tick, frame_start, swap_ack, buf_sel
    );

    modport slave (
        output swap_req,
        input  hcount, vcount, hsync, vsync, at_display_area,
        input  pix_tick, frame_start, swap_ack, buf_sel
    );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster timing with pixel-clock divider and vblank-synchronised double-buffer swap.
// Latency: all outputs registered, zero skew between position and strobes; no backpressure (free-running).
module vga_timing_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic                            clk,
    input  logic                            reset,
    vga_timing_controller_if.master         vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]      HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       V_PRE_BL = 10'(V_ACTIVE - 1);
    localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

    // running is low for the one edge after reset so that (0,0) with div_cnt 0
    // is presented for a full pixel period once reset is released.
    logic             running;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [10:0]      h_q;
    logic [10:0]      h_nxt;
    logic [9:0]       v_q;
    logic [9:0]       v_nxt;
    logic             tick;
    logic             h_wrap;
    logic             vblank_edge;

    logic             hsync_q;
    logic             vsync_q;
    logic             disp_q;
    logic             tick_q;
    logic             fs_q;

    swap_state_t      swap_state;
    logic             ack_q;
    logic             buf_q;

    always_comb begin
        tick        = running && (div_cnt == DIV_LAST);
        h_wrap      = tick && (h_q == H_LAST);
        vblank_edge = h_wrap && (v_q == V_PRE_BL);

        div_nxt = div_cnt;
        h_nxt   = h_q;
        v_nxt   = v_q;
        if (running) begin
            div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
        end
        if (tick) begin
            h_nxt = h_wrap ? '0 : h_q + 11'd1;
        end
        if (h_wrap) begin
            v_nxt = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Strobes are derived from the next position so they land on the same edge as the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            div_cnt <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            disp_q  <= 1'b0;
            tick_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            running <= 1'b1;
            div_cnt <= div_nxt;
            h_q     <= h_nxt;
            v_q     <= v_nxt;
            hsync_q <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
            vsync_q <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
            disp_q  <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            tick_q  <= (div_nxt == DIV_LAST);
            fs_q    <= (div_nxt == DIV_LAST) && (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // A request arriving on the applying edge re-arms PENDING for the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            swap_state <= IDLE;
            ack_q      <= 1'b0;
            buf_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (swap_state)
                IDLE: begin
                    if (vga.swap_req) begin
                        swap_state <= PENDING;
                    end
                end
                PENDING: begin
                    if (vblank_edge) begin
                        ack_q      <= 1'b1;
                        buf_q      <= ~buf_q;
                        swap_state <= vga.swap_req ? PENDING : IDLE;
                    end
                end
                default: swap_state <= IDLE;
            endcase
        end
    end

    assign vga.hcount          = h_q;
    assign vga.vcount          = v_q;
    assign vga.hsync           = hsync_q;
    assign vga.vsync           = vsync_q;
    assign vga.at_display_area = disp_q;
    assign vga.pix_tick        = tick_q;
    assign vga.frame_start     = fs_q;
    assign vga.swap_ack        = ack_q;
    assign vga.buf_sel         = buf_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller on a shrunken raster; reference model derives
// every output from the absolute cycle index since reset release.
module tb_vga_timing_controller;

    localparam int CD = 3;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 2, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = CD * HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_timing_controller_if vif ();

    vga_timing_controller #(
        .CLK_DIV (CD),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif)
    );

    typedef struct packed {
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        hsync;
        logic        vsync;
        logic        disp;
        logic        pix_tick;
        logic        frame_start;
        logic        swap_ack;
        logic        buf_sel;
    } obs_t;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic da;
    } probe_t;

    int n_checks = 0;
    int n_pass   = 0;

    int  k;
    bit  m_pend, m_buf, m_ack;
    int  ack_seen;
    int  ack_h, ack_v;
    int  fs_k[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, k);
    endtask

    function automatic int pos_h(input int kk);
        return (kk / CD) % HT;
    endfunction

    function automatic int pos_v(input int kk);
        return (kk / (CD * HT)) % VT;
    endfunction

    function automatic bit is_vb(input int kk);
        return ((kk % CD) == CD - 1) && (pos_h(kk) == HT - 1) && (pos_v(kk) == VA - 1);
    endfunction

    function automatic obs_t expect_at(input int kk);
        obs_t e;
        int   h, v;
        bit   t;
        h = pos_h(kk);
        v = pos_v(kk);
        t = (kk % CD) == CD - 1;
        e.hcount      = 11'(h);
        e.vcount      = 10'(v);
        e.hsync       = !(h >= HA + HF && h < HA + HF + HS);
        e.vsync       = !(v >= VA + VF && v < VA + VF + VS);
        e.disp        = (h < HA) && (v < VA);
        e.pix_tick    = t;
        e.frame_start = t && h == 0 && v == 0;
        e.swap_ack    = m_ack;
        e.buf_sel     = m_buf;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.hcount      = vif.hcount;
        s.vcount      = vif.vcount;
        s.hsync       = vif.hsync;
        s.vsync       = vif.vsync;
        s.disp        = vif.at_display_area;
        s.pix_tick    = vif.pix_tick;
        s.frame_start = vif.frame_start;
        s.swap_ack    = vif.swap_ack;
        s.buf_sel     = vif.buf_sel;
        return s;
    endfunction

    // One clock: compare cycle k against the model, then drive swap_req for cycle k.
    task automatic step(input bit req);
        obs_t got, exp;
        @(posedge clk);
        #1;
        got = sample();
        exp = expect_at(k);
        check("cycle", 32'(got), 32'(exp));
        if (got.swap_ack) begin
            ack_seen++;
            ack_h = int'(got.hcount);
            ack_v = int'(got.vcount);
        end
        if (got.frame_start) fs_k.push_back(k);
        vif.swap_req = req;
        m_ack = is_vb(k) && m_pend;
        if (m_ack) begin
            m_buf  = !m_buf;
            m_pend = req;
        end else begin
            m_pend = m_pend | req;
        end
        k++;
    endtask

    task automatic do_reset();
        obs_t got, exp;
        reset = 1'b1;
        vif.swap_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        exp = '{hcount: 11'd0, vcount: 10'd0, hsync: 1'b1, vsync: 1'b1, disp: 1'b0,
                pix_tick: 1'b0, frame_start: 1'b0, swap_ack: 1'b0, buf_sel: 1'b0};
        check("reset_state", 32'(got), 32'(exp));
        reset = 1'b0;
        k = 0; m_pend = 0; m_buf = 0; m_ack = 0;
        ack_seen = 0; ack_h = -1; ack_v = -1;
        fs_k.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        probe_t tbl[15];
        int     n;
        bit     found;

        tbl[0]  = '{0, 0, 1, 1, 1};   tbl[1]  = '{7, 0, 1, 1, 1};
        tbl[2]  = '{8, 0, 1, 1, 0};   tbl[3]  = '{10, 0, 0, 1, 0};
        tbl[4]  = '{12, 2, 0, 1, 0};  tbl[5]  = '{13, 2, 1, 1, 0};
        tbl[6]  = '{9, 3, 1, 1, 0};   tbl[7]  = '{7, 5, 1, 1, 1};
        tbl[8]  = '{14, 5, 1, 1, 0};  tbl[9]  = '{0, 6, 1, 1, 0};
        tbl[10] = '{3, 7, 1, 1, 0};   tbl[11] = '{3, 8, 1, 0, 0};
        tbl[12] = '{11, 9, 0, 0, 0};  tbl[13] = '{5, 10, 1, 1, 0};
        tbl[14] = '{14, 10, 1, 1, 0};

        vif.swap_req = 1'b0;

        // Reset release: (0,0) held, first pix_tick CD-1 cycles later with frame_start.
        do_reset();
        step(0);
        check("first_disp", vif.at_display_area, 1);
        n = 0;
        found = 0;
        for (int i = 0; i < 4 * CD && !found; i++) begin
            step(0);
            n++;
            if (vif.pix_tick) found = 1;
        end
        check("first_tick_delay", n, CD - 1);
        check("first_tick_fs", vif.frame_start, 1);

        // Position probes from the table.
        for (int t = 0; t < 15; t++) begin
            found = 0;
            for (int i = 0; i < 2 * FRAME && !found; i++) begin
                step(0);
                if (int'(vif.hcount) == tbl[t].h && int'(vif.vcount) == tbl[t].v) found = 1;
            end
            check($sformatf("probe%0d_found", t), found, 1);
            check($sformatf("probe%0d_hs_vs_da", t),
                  {vif.hsync, vif.vsync, vif.at_display_area},
                  {tbl[t].hs, tbl[t].vs, tbl[t].da});
        end

        // Duty counts over one line window and one frame window.
        n = 0;
        for (int i = 0; i < HT * CD; i++) begin
            step(0);
            if (!vif.hsync) n++;
        end
        check("hsync_low_clks", n, HS * CD);
        begin
            int nv, nd;
            nv = 0;
            nd = 0;
            for (int i = 0; i < FRAME; i++) begin
                step(0);
                if (!vif.vsync) nv++;
                if (vif.at_display_area) nd++;
            end
            check("vsync_low_clks", nv, VS * HT * CD);
            check("display_clks", nd, HA * VA * CD);
        end
        check("fs_count", fs_k.size() >= 3, 1);
        for (int i = 1; i < fs_k.size(); i++)
            check($sformatf("fs_spacing%0d", i), fs_k[i] - fs_k[i-1], FRAME);

        // Three requests during line 2 merge into a single swap at the vblank edge.
        do_reset();
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (pos_v(k) == 2) found = 1;
            else step(0);
        end
        check("line2_reached", found, 1);
        step(1); step(0); step(1); step(0); step(1);
        repeat (2 * FRAME) step(0);
        check("merge_ack_count", ack_seen, 1);
        check("merge_ack_pos", {ack_h, ack_v}, {32'd0, 32'(VA)});
        check("merge_buf_sel", vif.buf_sel, 1);

        // Pending plus a fresh request on the vblank-edge cycle: two swaps, buffer 0->1->0.
        do_reset();
        step(1);
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (is_vb(k)) found = 1;
            else step(0);
        end
        check("vb_reached", found, 1);
        step(1);
        check("edge_ack_now", vif.swap_ack, 0);
        step(0);
        check("edge_ack_next", vif.swap_ack, 1);
        check("edge_buf_first", vif.buf_sel, 1);
        repeat (2 * FRAME) step(0);
        check("edge_ack_count", ack_seen, 2);
        check("edge_buf_final", vif.buf_sel, 0);

        // Reset mid-frame while pending discards the swap.
        do_reset();
        step(1);
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (pos_h(k) == 5 && pos_v(k) == 3) found = 1;
            else step(0);
        end
        check("midframe_reached", found, 1);
        do_reset();
        repeat (2 * FRAME) step(0);
        check("reset_drop_ack", ack_seen, 0);
        check("reset_drop_buf", vif.buf_sel, 0);

        // Random swap traffic with one reset thrown in.
        do_reset();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (i == 2 * FRAME + 137) do_reset();
            step($urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
